// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants and the load funct3 encoding.
package rv_pkg;

  localparam int unsigned REGISTER_ADDRESS_WIDTH = 5;
  localparam int unsigned DATA_WIDTH             = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/load_extend.sv
// Selects the byte/half lane of an aligned load word and sign/zero extends it;
// flags misaligned accesses and unknown funct3 encodings.
module load_extend
  import rv_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  error
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(word >> {offset, 3'b000});
    half_lane = offset[1] ? word[31:16] : word[15:0];
    data      = '0;
    error     = 1'b0;
    case (funct3)
      LB:  data = {{(DATA_WIDTH - 8){byte_lane[7]}}, byte_lane};
      LBU: data = {{(DATA_WIDTH - 8){1'b0}}, byte_lane};
      LH: begin
        data  = {{(DATA_WIDTH - 16){half_lane[15]}}, half_lane};
        error = offset[0];
      end
      LHU: begin
        data  = {{(DATA_WIDTH - 16){1'b0}}, half_lane};
        error = offset[0];
      end
      LW: begin
        data  = word;
        error = (offset != 2'b00);
      end
      default: error = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// Sole owner of the register-file write port: arbitrates ALU results against
// load responses (ALU first), with a one-entry buffer for a displaced load.
module rf_writeback
  import rv_pkg::*;
(
  input  logic                              clk,
  input  logic                              s_reset,
  input  logic                              alu_valid,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]             alu_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] ld_rd,
  input  logic [2:0]                        ld_funct3,
  input  logic [1:0]                        ld_offset,
  input  logic [DATA_WIDTH-1:0]             ld_word,
  output logic                              rf_we,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0]             rf_write_data,
  output logic                              ld_pending,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] ld_pending_rd,
  output logic                              ld_error
);

  typedef enum logic {EMPTY, HELD} state_e;

  state_e                            state, state_next;
  logic [REGISTER_ADDRESS_WIDTH-1:0] buf_rd, buf_rd_next;
  logic [DATA_WIDTH-1:0]             buf_data, buf_data_next;
  logic                              rf_we_next;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address_next;
  logic [DATA_WIDTH-1:0]             rf_write_data_next;
  logic                              ld_error_next;

  logic [DATA_WIDTH-1:0]             ext_data;
  logic                              ext_error;
  logic                              accept;
  logic                              good_load;

  load_extend u_load_extend (
    .funct3 (ld_funct3),
    .offset (ld_offset),
    .word   (ld_word),
    .data   (ext_data),
    .error  (ext_error)
  );

  assign ld_ready      = (state == EMPTY) & ~s_reset;
  assign accept        = ld_valid & ld_ready;
  assign good_load     = accept & ~ext_error;
  assign ld_pending    = (state == HELD);
  assign ld_pending_rd = buf_rd;

  // Write selection: ALU, then buffered load, then a freshly accepted load.
  always_comb begin
    state_next         = state;
    buf_rd_next        = buf_rd;
    buf_data_next      = buf_data;
    rf_we_next         = 1'b0;
    rf_address_next    = rf_address;
    rf_write_data_next = rf_write_data;
    ld_error_next      = accept & ext_error;

    if (alu_valid) begin
      rf_we_next         = (alu_rd != '0);
      rf_address_next    = alu_rd;
      rf_write_data_next = alu_data;
      if (good_load) begin
        state_next    = HELD;
        buf_rd_next   = ld_rd;
        buf_data_next = ext_data;
      end
    end else if (state == HELD) begin
      rf_we_next         = (buf_rd != '0);
      rf_address_next    = buf_rd;
      rf_write_data_next = buf_data;
      state_next         = EMPTY;
    end else if (good_load) begin
      rf_we_next         = (ld_rd != '0);
      rf_address_next    = ld_rd;
      rf_write_data_next = ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state         <= EMPTY;
      buf_rd        <= '0;
      buf_data      <= '0;
      rf_we         <= 1'b0;
      rf_address    <= '0;
      rf_write_data <= '0;
      ld_error      <= 1'b0;
    end else begin
      state         <= state_next;
      buf_rd        <= buf_rd_next;
      buf_data      <= buf_data_next;
      rf_we         <= rf_we_next;
      rf_address    <= rf_address_next;
      rf_write_data <= rf_write_data_next;
      ld_error      <= ld_error_next;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: single-source vector table plus collision,
// x0 and reset sequences.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        s_reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [31:0] ld_word;
  logic        rf_we;
  logic [4:0]  rf_address;
  logic [31:0] rf_write_data;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        ld_error;

  int total = 0;
  int bad   = 0;

  rf_writeback dut (
    .clk           (clk),
    .s_reset       (s_reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_funct3     (ld_funct3),
    .ld_offset     (ld_offset),
    .ld_word       (ld_word),
    .rf_we         (rf_we),
    .rf_address    (rf_address),
    .rf_write_data (rf_write_data),
    .ld_pending    (ld_pending),
    .ld_pending_rd (ld_pending_rd),
    .ld_error      (ld_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
    logic        chk_ad;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_funct3 = '0;
    ld_offset = '0;
    ld_word   = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] w);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_funct3 = f3;
    ld_offset = off;
    ld_word   = w;
  endtask

  initial begin
    //          av   ard    adata          lv   lrd    f3      off    word           we   addr   data           err  chk_ad
    vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,         1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  3'b000, 2'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  3'b000, 2'd3, 32'h80FF_0000, 1'b1, 5'd7,  32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  3'b100, 2'd3, 32'h80FF_0000, 1'b1, 5'd7,  32'h0000_0080, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  3'b001, 2'd2, 32'h8001_0000, 1'b1, 5'd9,  32'hFFFF_8001, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 3'b101, 2'd0, 32'h1234_F00D, 1'b1, 5'd10, 32'h0000_F00D, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 3'b010, 2'd0, 32'hCAFE_BABE, 1'b1, 5'd11, 32'hCAFE_BABE, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 3'b000, 2'd1, 32'h0000_7F00, 1'b1, 5'd12, 32'h0000_007F, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd13, 3'b010, 2'd2, 32'h1111_1111, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  3'b000, 2'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd14, 3'b001, 2'd1, 32'h2222_2222, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd15, 3'b011, 2'd0, 32'h3333_3333, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  3'b010, 2'd0, 32'h0000_0005, 1'b0, 5'd0,  32'h0000_0005, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd16, 3'b101, 2'd2, 32'hBEEF_0000, 1'b1, 5'd16, 32'h0000_BEEF, 1'b0, 1'b1};

    // Reset state, with a load offered during reset that must not be taken.
    idle();
    s_reset = 1'b1;
    drive_ld(5'd20, 3'b010, 2'd0, 32'h5555_5555);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   32'(ld_ready),      32'h0);
    chk("rst_we",      32'(rf_we),         32'h0);
    chk("rst_addr",    32'(rf_address),    32'h0);
    chk("rst_data",    rf_write_data,      32'h0);
    chk("rst_pend",    32'(ld_pending),    32'h0);
    chk("rst_pend_rd", 32'(ld_pending_rd), 32'h0);
    chk("rst_err",     32'(ld_error),      32'h0);
    idle();
    s_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 32'(rf_we), 32'h0);

    // Table: one source per cycle, result visible one cycle later.
    for (int i = 0; i < 14; i++) begin
      idle();
      if (vecs[i].av) drive_alu(vecs[i].ard, vecs[i].adata);
      if (vecs[i].lv) drive_ld(vecs[i].lrd, vecs[i].f3, vecs[i].off, vecs[i].word);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_we", i),   32'(rf_we),      32'(vecs[i].we));
      chk($sformatf("v%0d_err", i),  32'(ld_error),   32'(vecs[i].err));
      chk($sformatf("v%0d_pend", i), 32'(ld_pending), 32'h0);
      if (vecs[i].chk_ad) begin
        chk($sformatf("v%0d_addr", i), 32'(rf_address), 32'(vecs[i].addr));
        chk($sformatf("v%0d_data", i), rf_write_data,    vecs[i].data);
      end
    end
    idle();
    @(negedge clk);
    chk("tbl_tail_we",  32'(rf_we),    32'h0);
    chk("tbl_tail_err", 32'(ld_error), 32'h0);

    // x0 ALU write: suppressed, then no write for 3 cycles.
    drive_alu(5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("x0_we",   32'(rf_we),      32'h0);
    chk("x0_addr", 32'(rf_address), 32'h0);
    chk("x0_data", rf_write_data,   32'hDEAD_BEEF);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("x0_quiet%0d", k), 32'(rf_we), 32'h0);
    end

    // Collision: writes x1, x3, x2 on consecutive cycles.
    drive_alu(5'd1, 32'h11);
    drive_ld(5'd2, 3'b010, 2'd0, 32'h22);
    #1;
    chk("col_ready0", 32'(ld_ready), 32'h1);
    @(negedge clk);
    chk("col1_we",      32'(rf_we),         32'h1);
    chk("col1_addr",    32'(rf_address),    32'd1);
    chk("col1_data",    rf_write_data,      32'h11);
    chk("col1_pend",    32'(ld_pending),    32'h1);
    chk("col1_pend_rd", 32'(ld_pending_rd), 32'd2);
    chk("col1_ready",   32'(ld_ready),      32'h0);
    idle();
    drive_alu(5'd3, 32'h33);
    @(negedge clk);
    chk("col2_we",      32'(rf_we),         32'h1);
    chk("col2_addr",    32'(rf_address),    32'd3);
    chk("col2_data",    rf_write_data,      32'h33);
    chk("col2_pend",    32'(ld_pending),    32'h1);
    chk("col2_pend_rd", 32'(ld_pending_rd), 32'd2);
    chk("col2_ready",   32'(ld_ready),      32'h0);
    idle();
    @(negedge clk);
    chk("col3_we",    32'(rf_we),      32'h1);
    chk("col3_addr",  32'(rf_address), 32'd2);
    chk("col3_data",  rf_write_data,   32'h22);
    chk("col3_pend",  32'(ld_pending), 32'h0);
    chk("col3_ready", 32'(ld_ready),   32'h1);
    @(negedge clk);
    chk("col4_we", 32'(rf_we), 32'h0);

    // Reset with a load held in the buffer: it must never be written.
    drive_alu(5'd4, 32'h44);
    drive_ld(5'd6, 3'b010, 2'd0, 32'h66);
    @(negedge clk);
    chk("rmid_pend",    32'(ld_pending),    32'h1);
    chk("rmid_pend_rd", 32'(ld_pending_rd), 32'd6);
    idle();
    s_reset = 1'b1;
    #1;
    chk("rmid_ready_in_rst", 32'(ld_ready), 32'h0);
    @(negedge clk);
    chk("rmid_we",      32'(rf_we),         32'h0);
    chk("rmid_addr",    32'(rf_address),    32'h0);
    chk("rmid_data",    rf_write_data,      32'h0);
    chk("rmid_pend2",   32'(ld_pending),    32'h0);
    chk("rmid_pend_rd2", 32'(ld_pending_rd), 32'h0);
    chk("rmid_err",     32'(ld_error),      32'h0);
    s_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rmid_quiet%0d", k), 32'(rf_we), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
Writer side of the integer register file: the single owner of its write port (we, address3, write_data). Merges ALU results and load-unit responses into one registered write per cycle, extends load data by size/offset, and suppresses x0 writes. Also exports a forwarding copy of the write in flight and a pending-load indication for hazard logic, because the register file's read ports are registered and return pre-write data.

Parameters:
REGISTER_ADDRESS_WIDTH, 5, register index width
DATA_WIDTH, 32, datapath width (32 only; byte/half extraction assumes 4 lanes)

Ports:
clk  input  1  clock, all logic on posedge
s_reset  input  1  synchronous reset, active-high
alu_valid  input  1  ALU result present this cycle; cannot be stalled
alu_rd  input  REGISTER_ADDRESS_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
ld_valid  input  1  load response valid
ld_ready  output  1  load response accepted when ld_valid & ld_ready
ld_rd  input  REGISTER_ADDRESS_WIDTH  load destination register
ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ld_offset  input  2  byte address bits [1:0]
ld_word  input  DATA_WIDTH  raw aligned memory word
rf_we  output  1  register-file write enable
rf_address  output  REGISTER_ADDRESS_WIDTH  register-file write index
rf_write_data  output  DATA_WIDTH  register-file write data
ld_pending  output  1  a load is held in the internal buffer
ld_pending_rd  output  REGISTER_ADDRESS_WIDTH  destination of the held load
ld_error  output  1  one-cycle pulse for an illegal funct3 or misaligned load

Behaviour:
- Reset (s_reset=1 at posedge): rf_we=0, rf_address=0, rf_write_data=0, ld_pending=0, ld_pending_rd=0, ld_error=0. Any held load is discarded. ld_ready=0 while s_reset is high.
- Internal state is a one-entry load buffer (EMPTY/HELD) holding the already-extended data and its rd.
- ld_ready = ~HELD (combinational from state). Handshake: a load transfers only when ld_valid & ld_ready.
- Write selection each cycle, in priority order:
  1. alu_valid: write the ALU result.
  2. HELD: write the buffered load.
  3. Accepted load: write the new load directly.
- A load accepted in the same cycle as an ALU write goes into the buffer (EMPTY->HELD).
- HELD->EMPTY when the buffered load is written. No accept is possible while HELD.
- Latency: all outputs are registered. The ALU write appears 1 cycle after alu_valid. An uncontended load appears 1 cycle after acceptance, plus 1 cycle for each consecutive ALU cycle that blocks it.
- x0: a selected write with rd==0 is consumed but rf_we=0 that cycle. rf_address and rf_write_data still update.
- Load extension, with byte lane = ld_offset and half lane = ld_offset[1]:
  - LB / LH: sign-extend the selected byte / half.
  - LBU / LHU: zero-extend.
  - LW: pass ld_word through.
- Load errors:
  - Misaligned: LH/LHU with ld_offset[0]=1, or LW with ld_offset!=0.
  - Illegal funct3: any other funct3 value.
  - On error the load is accepted, not written and not buffered; ld_error pulses 1 cycle after acceptance.
- ld_pending mirrors HELD; ld_pending_rd holds the buffered rd. Both are registered.
- rf_we is high for exactly one cycle per write. No write is ever duplicated or dropped except x0 writes and error loads.

Decomposition:
- Shared package (rv_pkg): load funct3 enum (LB, LH, LW, LBU, LHU) and the REGISTER_ADDRESS_WIDTH and DATA_WIDTH constants.
- Sub-module load_extend: purely combinational (funct3, offset, word) -> (data, error). It is reused by the later load/store unit.

Test Plan:
- ALU write: alu_valid, rd=5, data=0x0000_1234 -> next cycle rf_we=1, rf_address=5, rf_write_data=0x0000_1234, then rf_we=0.
- x0 suppression: alu_valid, rd=0, data=0xDEAD_BEEF -> next cycle rf_we=0, and no register-file write in the following 3 cycles.
- Byte extension: LB, offset 3, word 0x80FF_0000, rd=7 -> write 0xFFFF_FF80 to x7; LBU with the same inputs -> 0x0000_0080. LH, offset 2, word 0x8001_0000 -> 0xFFFF_8001.
- Collision: ALU (rd=1, 0x11) and load (LW rd=2, 0x22) in the same cycle, then ALU (rd=3, 0x33) next cycle:
  - Writes occur in the order x1, x3, x2 on consecutive cycles.
  - ld_ready=0 and ld_pending=1 with ld_pending_rd=2 for 2 cycles.
- Misaligned: LW offset 2 -> ld_error=1 for exactly 1 cycle, rf_we=0, ld_ready stays 1.
- Reset mid-operation: hold a load in the buffer, then assert s_reset for 1 cycle -> all outputs 0, and the buffered load is never written after reset deasserts.
